vga_timing_out: RTL and testbench

- Display-side driver for the VGA path; produces the sx/sy pixel coordinates that the paint blocks consume.
- Also produces a single-cycle frame_start pulse.
- Takes the combinational paint_r/g/b those blocks return, blanks it outside the active area, and registers colour and sync onto the VGA pins with matched latency.
- Default timing: 640x480@60, 800x525 total, one pixel per pix_stb.

---
 rtl/vga_timing_out.sv | 128 ++++++++++++
 tb/tb_vga_timing_out.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_out.sv
// VGA display-side timing: pixel divider, sx/sy raster counters, sync decode
// and a registered pin stage that keeps colour and sync aligned one pixel behind sx/sy.
module vga_timing_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int CLK_DIV  = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_stb,
    output logic [9:0] sx,
    output logic [9:0] sy,
    output logic       de,
    output logic       frame_start,
    input  logic [3:0] paint_r,
    input  logic [3:0] paint_g,
    input  logic [3:0] paint_b,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);
    localparam logic       SYNC_ACT = (SYNC_POL != 0);

    if (H_TOTAL > 1024) begin : g_h_total_chk
        $error("vga_timing_out: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_v_total_chk
        $error("vga_timing_out: V_TOTAL exceeds 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_div_chk
        $error("vga_timing_out: CLK_DIV must be 1..4");
    end

    logic [1:0] div_q, div_d;
    logic [9:0] sx_q, sx_d;
    logic [9:0] sy_q, sy_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic [3:0] r_q, r_d;
    logic [3:0] g_q, g_d;
    logic [3:0] b_q, b_d;
    logic       hs_act, vs_act;

    always_comb begin
        div_d   = (div_q == DIV_LAST) ? '0 : div_q + 2'd1;
        pix_stb = (div_q == DIV_LAST) && !rst;

        // Comparisons are done 11 bits wide so range ends of 1024 still fit.
        de     = ({1'b0, sx_q} < 11'(H_ACTIVE)) && ({1'b0, sy_q} < 11'(V_ACTIVE));
        hs_act = ({1'b0, sx_q} >= 11'(HS_START)) && ({1'b0, sx_q} < 11'(HS_END));
        vs_act = ({1'b0, sy_q} >= 11'(VS_START)) && ({1'b0, sy_q} < 11'(VS_END));

        frame_start = pix_stb && (sy_q == 10'(V_ACTIVE)) && (sx_q == '0);

        sx_d    = sx_q;
        sy_d    = sy_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;

        if (pix_stb) begin
            if (sx_q == H_LAST) begin
                sx_d = '0;
                sy_d = (sy_q == V_LAST) ? '0 : sy_q + 10'd1;
            end else begin
                sx_d = sx_q + 10'd1;
            end
            hsync_d = hs_act ? SYNC_ACT : ~SYNC_ACT;
            vsync_d = vs_act ? SYNC_ACT : ~SYNC_ACT;
            r_d     = de ? paint_r : '0;
            g_d     = de ? paint_g : '0;
            b_d     = de ? paint_b : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            hsync_q <= ~SYNC_ACT;
            vsync_q <= ~SYNC_ACT;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            div_q   <= div_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign sx        = sx_q;
    assign sy        = sy_q;
    assign vga_hsync = hsync_q;
    assign vga_vsync = vsync_q;
    assign vga_r     = r_q;
    assign vga_g     = g_q;
    assign vga_b     = b_q;

endmodule

// File: tb/tb_vga_timing_out.sv
// Directed bench for vga_timing_out using a reduced raster (24x13 total) so whole
// frames fit in a short run; one instance at CLK_DIV=1 active-low sync, one at CLK_DIV=2 active-high.
module tb_vga_timing_out;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_stb, a_de, a_fs, a_hs, a_vs;
    logic [9:0] a_sx, a_sy;
    logic [3:0] a_pr, a_pg, a_pb, a_r, a_g, a_b;
    logic       b_stb, b_de, b_fs, b_hs, b_vs;
    logic [9:0] b_sx, b_sy;
    logic [3:0] b_r, b_g, b_b;
    logic [3:0] b_paint = 4'hF;

    // Paint block stand-in for instance A: colour depends on position.
    assign a_pr = a_sx[3:0] ^ 4'h5;
    assign a_pg = a_sy[3:0];
    assign a_pb = 4'hF;

    vga_timing_out #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(0),  .CLK_DIV(1)
    ) u_a (
        .clk(clk), .rst(rst), .pix_stb(a_stb), .sx(a_sx), .sy(a_sy), .de(a_de),
        .frame_start(a_fs), .paint_r(a_pr), .paint_g(a_pg), .paint_b(a_pb),
        .vga_hsync(a_hs), .vga_vsync(a_vs), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b)
    );

    vga_timing_out #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1),  .CLK_DIV(2)
    ) u_b (
        .clk(clk), .rst(rst), .pix_stb(b_stb), .sx(b_sx), .sy(b_sy), .de(b_de),
        .frame_start(b_fs), .paint_r(b_paint), .paint_g(b_paint), .paint_b(b_paint),
        .vga_hsync(b_hs), .vga_vsync(b_vs), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raster position of pixel index p (24 pixels per line, 13 lines per frame).
    function automatic int hx(input int p);
        return p % 24;
    endfunction
    function automatic int vy(input int p);
        return (p / 24) % 13;
    endfunction
    function automatic bit act(input int p);
        return (hx(p) < 16) && (vy(p) < 8);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // k = clk edges since the last edge that sampled rst high (k=0: held in reset).
    task automatic check_a(input int k);
        int q;
        check("a_sx", a_sx, hx(k));
        check("a_sy", a_sy, vy(k));
        check("a_de", a_de, act(k));
        check("a_stb", a_stb, k > 0);
        check("a_fs", a_fs, (k > 0) && (k % 312 == 192));
        if (k == 0) begin
            check("a_hs", a_hs, 1);
            check("a_vs", a_vs, 1);
            check("a_rgb", {a_r, a_g, a_b}, 0);
        end else begin
            q = k - 1;
            check("a_hs", a_hs, !(hx(q) >= 18 && hx(q) <= 20));
            check("a_vs", a_vs, !(vy(q) >= 9 && vy(q) <= 10));
            check("a_r", a_r, act(q) ? (hx(q) ^ 5) : 0);
            check("a_g", a_g, act(q) ? vy(q) : 0);
            check("a_b", a_b, act(q) ? 15 : 0);
        end
    endtask

    task automatic check_b(input int k);
        int p, q;
        p = k / 2;
        check("b_sx", b_sx, hx(p));
        check("b_sy", b_sy, vy(p));
        check("b_de", b_de, act(p));
        check("b_stb", b_stb, k % 2 == 1);
        check("b_fs", b_fs, (k % 2 == 1) && (p % 312 == 192));
        if (p == 0) begin
            check("b_hs", b_hs, 0);
            check("b_vs", b_vs, 0);
            check("b_rgb", {b_r, b_g, b_b}, 0);
        end else begin
            q = p - 1;
            check("b_hs", b_hs, hx(q) >= 18 && hx(q) <= 20);
            check("b_vs", b_vs, vy(q) >= 9 && vy(q) <= 10);
            check("b_rgb", {b_r, b_g, b_b}, act(q) ? 32'hFFF : 0);
        end
    endtask

    initial begin
        int last_a, last_b, hs_run_a, vs_run_a, hs_run_b, vs_run_b;
        last_a = -1; last_b = -1;
        hs_run_a = 0; vs_run_a = 0; hs_run_b = 0; vs_run_b = 0;

        rst = 1'b1;
        repeat (3) step();
        check_a(0);
        check_b(0);
        rst = 1'b0;

        // Run into the frame so A's pins show pixel (19,9): hsync and vsync both active.
        for (int k = 1; k <= 236; k++) begin
            step();
            check_a(k);
            check_b(k);
        end
        check("a_hs_mid", a_hs, 0);
        check("a_vs_mid", a_vs, 0);

        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_a(0);
            check_b(0);
            check("a_de_rst", a_de, 1);
        end
        rst = 1'b0;

        step();
        check("a_sx_rel1", a_sx, 1);
        check("b_sx_rel1", b_sx, 0);
        check_a(1);
        check_b(1);
        step();
        check("a_sx_rel2", a_sx, 2);
        check("b_sx_rel2", b_sx, 1);
        check_a(2);
        check_b(2);
        step();
        check("a_sx_rel3", a_sx, 3);
        check("b_sx_rel3", b_sx, 1);
        check_a(3);
        check_b(3);

        for (int k = 4; k <= 1300; k++) begin
            step();
            check_a(k);
            check_b(k);

            if (!a_hs) hs_run_a++;
            else if (hs_run_a > 0) begin check("a_hs_width", hs_run_a, 3); hs_run_a = 0; end
            if (!a_vs) vs_run_a++;
            else if (vs_run_a > 0) begin check("a_vs_width", vs_run_a, 48); vs_run_a = 0; end
            if (b_hs) hs_run_b++;
            else if (hs_run_b > 0) begin check("b_hs_width", hs_run_b, 6); hs_run_b = 0; end
            if (b_vs) vs_run_b++;
            else if (vs_run_b > 0) begin check("b_vs_width", vs_run_b, 96); vs_run_b = 0; end

            if (a_fs) begin
                if (last_a >= 0) check("a_fs_period", k - last_a, 312);
                last_a = k;
            end
            if (b_fs) begin
                if (last_b >= 0) check("b_fs_period", k - last_b, 624);
                last_b = k;
            end
        end
        check("a_fs_last", last_a, 1128);
        check("b_fs_last", last_b, 1009);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
